// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a first-word-fall-through TX FIFO into 8N1-style frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo_drain #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done_tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam int unsigned IdxW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_SIZE-1:0]  shift_q;
  logic [DATA_SIZE-1:0]  shift_nxt;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  always_comb begin
    shift_nxt = shift_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      tx           <= 1'b1;
      fifo_read    <= 1'b0;
      busy         <= 1'b0;
      tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      fifo_read    <= 1'b0;
      tx_done_tick <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          // The word is captured here; the FIFO pops on the following edge.
          if (!fifo_empty) begin
            shift_q   <= fifo_data;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^fifo_data;
`endif
            fifo_read <= 1'b1;
            tx        <= 1'b0;
            busy      <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx      <= shift_q[0];
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
              tx      <= parity_q;
              state_q <= StParity;
`else
              tx      <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              shift_q <= shift_nxt;
              tx      <= shift_nxt[0];
              idx_q   <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            tx      <= 1'b1;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        StStop: begin
          if (cnt_q == StopLast) begin
            cnt_q        <= '0;
            tx_done_tick <= 1'b1;
            busy         <= 1'b0;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: queue-backed FIFO models feed a 1-stop and a 2-stop instance,
// and each frame is compared cycle by cycle against a slot-based frame model.
module tb_uart_tx_fifo_drain;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       empty1 = 1'b1, empty2 = 1'b1;
  logic [7:0] data1 = 8'h00, data2 = 8'h00;
  logic       rd1, rd2, tx1, tx2, busy1, busy2, done1, done2;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int vectors = 0, miscompares = 0;
  int rd_cnt1 = 0, rd_cnt2 = 0, exp_rd1 = 0, exp_rd2 = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.DATA_SIZE(8), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(empty1), .fifo_data(data1),
    .fifo_read(rd1), .tx(tx1), .busy(busy1), .tx_done_tick(done1)
  );

  uart_tx_fifo_drain #(.DATA_SIZE(8), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .fifo_empty(empty2), .fifo_data(data2),
    .fifo_read(rd2), .tx(tx2), .busy(busy2), .tx_done_tick(done2)
  );

  // FWFT FIFO models: pop on the edge that sees fifo_read high.
  always @(posedge clk) begin
    if (rd1 === 1'b1 && q1.size() > 0) void'(q1.pop_front());
    if (rd2 === 1'b1 && q2.size() > 0) void'(q2.pop_front());
  end

  always @(negedge clk) begin
    empty1 = (q1.size() == 0);
    data1  = empty1 ? 8'h00 : q1[0];
    empty2 = (q2.size() == 0);
    data2  = empty2 ? 8'h00 : q2[0];
    if (rd1 === 1'b1) rd_cnt1++;
    if (rd2 === 1'b1) rd_cnt2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for a given bit slot of the frame.
  function automatic logic exp_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR == 1 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic sel_tx(input int s);   return (s == 2) ? tx2 : tx1;     endfunction
  function automatic logic sel_busy(input int s); return (s == 2) ? busy2 : busy1; endfunction
  function automatic logic sel_done(input int s); return (s == 2) ? done2 : done1; endfunction
  function automatic logic sel_rd(input int s);   return (s == 2) ? rd2 : rd1;     endfunction

  // s selects the instance and equals its stop-bit count; budget bounds the wait for start.
  task automatic expect_frame(input int s, input logic [7:0] b, input int budget);
    int len;
    int waited;
    len    = (1 + 8 + PAR + s) * C;
    waited = 0;
    @(negedge clk);
    while (sel_tx(s) !== 1'b0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("start_s%0d_%02h", s, b), {31'd0, sel_tx(s)}, 32'd0);
    if (sel_tx(s) !== 1'b0) return;
    check($sformatf("pop_s%0d_%02h", s, b), {31'd0, sel_rd(s)}, 32'd1);
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("tx_s%0d_%02h_c%0d", s, b, c), {31'd0, sel_tx(s)},
            {31'd0, exp_bit(b, c / C)});
      check($sformatf("busy_s%0d_%02h_c%0d", s, b, c),
            {30'd0, sel_busy(s), sel_done(s)}, 32'd2);
      if (c == 1) check($sformatf("pop1_s%0d_%02h", s, b), {31'd0, sel_rd(s)}, 32'd0);
    end
    @(negedge clk);
    check($sformatf("done_s%0d_%02h", s, b),
          {29'd0, sel_done(s), sel_busy(s), sel_tx(s)}, 32'b101);
  endtask

  initial begin
    logic [7:0] r [4];

    // Reset and idle with an empty FIFO.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_s1", {28'd0, tx1, busy1, rd1, done1}, 32'b1000);
    check("reset_s2", {28'd0, tx2, busy2, rd2, done2}, 32'b1000);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("idle_c%0d", i), {28'd0, tx1, busy1, rd1, done1}, 32'b1000);
    end

    // Preloaded word, then reset release.
    reset = 1'b1;
    @(posedge clk); #2;
    q1.push_back(8'hA5);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_frame(1, 8'hA5, 10);
    exp_rd1 += 1;
    repeat (5) @(negedge clk);
    #1 check("rd_count_a5", rd_cnt1, exp_rd1);

    // Three queued words go out back to back.
    @(posedge clk); #2;
    q1.push_back(8'h01); q1.push_back(8'h80); q1.push_back(8'hFF);
    expect_frame(1, 8'h01, 10);
    expect_frame(1, 8'h80, 0);
    expect_frame(1, 8'hFF, 0);
    exp_rd1 += 3;
    #1 check("rd_count_b2b", rd_cnt1, exp_rd1);
    check("fifo_empty_b2b", {31'd0, empty1}, 32'd1);

    // Random bytes, back to back.
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'($urandom);
      q1.push_back(r[i]);
    end
    for (int i = 0; i < 4; i++) expect_frame(1, r[i], (i == 0) ? 10 : 0);
    exp_rd1 += 4;

    // Parity-sensitive pair (plain frames when parity is disabled).
    @(posedge clk); #2;
    q1.push_back(8'h07); q1.push_back(8'h03);
    expect_frame(1, 8'h07, 10);
    expect_frame(1, 8'h03, 0);
    exp_rd1 += 2;
    repeat (3) @(negedge clk);
    #1 check("rd_count_rand", rd_cnt1, exp_rd1);

    // Reset in the middle of a frame.
    @(posedge clk); #2;
    q1.push_back(8'h3C);
    exp_rd1 += 1;
    begin
      int waited;
      waited = 0;
      @(negedge clk);
      while (tx1 !== 1'b0 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      check("start_3c", {31'd0, tx1}, 32'd0);
    end
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset", {28'd0, tx1, busy1, rd1, done1}, 32'b1000);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_c%0d", i), {30'd0, tx1, busy1}, 32'b10);
    end
    #1 check("rd_count_reset", rd_cnt1, exp_rd1);
    @(posedge clk); #2;
    q1.push_back(8'h55);
    expect_frame(1, 8'h55, 10);
    exp_rd1 += 1;

    // Two stop bits.
    @(posedge clk); #2;
    r[0] = 8'($urandom);
    q2.push_back(8'h00); q2.push_back(r[0]);
    expect_frame(2, 8'h00, 10);
    expect_frame(2, r[0], 0);
    exp_rd2 += 2;
    repeat (3) @(negedge clk);
    #1 check("rd_count_s1_final", rd_cnt1, exp_rd1);
    check("rd_count_s2_final", rd_cnt2, exp_rd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
